capture_sequencer: RTL and testbench

- Trigger-based capture controller for the logic-analyser datapath.
- Compresses probe samples into run-length entries {value, hold_count} and writes them into the single-port capture RAM as a circular buffer with configurable pre-trigger depth.
- After capture completes, reads the buffer back oldest-first and streams each entry MSB-first as bytes into the serial transmitter.
- Sits between the button debouncer, capture RAM (1-cycle registered read) and UART TX.

---
 rtl/capture_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_capture_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_sequencer.sv
// capture_sequencer: trigger-based run-length capture into a circular RAM
// buffer, followed by an oldest-first byte-serial readout to the UART TX.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | waiting for start
// PRE        | filling the pre-trigger history
// WAIT_TRIG  | capturing, watching for the trigger pattern
// POST       | capturing until the write pointer wraps onto start_addr
// RD_ADDR    | presenting rd_ptr to the RAM
// RD_LATCH   | loading the entry returned by the RAM into the shift word
// SEND       | waiting for tx_ready, then strobing the top byte
// SEND_WAIT  | one idle cycle after a strobe, then next byte/entry or done
//
// The RAM port and tx_send are decoded from the current state and inputs so
// that a write, a read address or a strobe lands in the same cycle as the
// decision. busy, triggered and done are registered.
module capture_sequencer #(
  parameter int DW = 16,
  parameter int CW = 16,
  parameter int AW = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DW-1:0]      probe_i,
  input  logic [DW-1:0]      trig_mask,
  input  logic [DW-1:0]      trig_value,
  input  logic [AW-1:0]      pretrig,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [DW+CW-1:0]   mem_wdata,
  input  logic [DW+CW-1:0]   mem_rdata,
  output logic [7:0]         tx_data,
  output logic               tx_send,
  input  logic               tx_ready,
  output logic               busy,
  output logic               triggered,
  output logic               done
);

  localparam int EW  = DW + CW;
  localparam int NB  = EW / 8;
  localparam int BIW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [2:0] {
    IDLE, PRE, WAIT_TRIG, POST, RD_ADDR, RD_LATCH, SEND, SEND_WAIT
  } state_t;

  state_t          state;
  logic [AW-1:0]   pretrig_q;
  logic [DW-1:0]   run_val;
  logic [CW-1:0]   run_cnt;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   n_wr;
  logic [AW-1:0]   start_addr;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   n_rd;
  logic [EW-1:0]   shift_q;
  logic [BIW-1:0]  byte_idx;

  logic            capturing;
  logic            run_hit;
  logic            trig_hit;
  logic [AW-1:0]   wr_nxt;

  assign capturing = (state == PRE) || (state == WAIT_TRIG) || (state == POST);
  // A run closes when the probe changes or its counter would overflow.
  assign run_hit   = (probe_i != run_val) || (run_cnt == {CW{1'b1}});
  assign trig_hit  = ((probe_i ^ trig_value) & trig_mask) == '0;
  assign wr_nxt    = wr_ptr + AW'(1);

  assign tx_send = (state == SEND) && tx_ready;
  assign tx_data = shift_q[EW-1 -: 8];

  // RAM port: run-length writes while capturing, read address in RD_ADDR.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (capturing) begin
      mem_addr = wr_ptr;
      if (run_hit) begin
        mem_we    = 1'b1;
        mem_wdata = {run_val, run_cnt};
      end
    end else if (state == RD_ADDR) begin
      mem_addr = rd_ptr;
    end
  end

  // Sequencer: run-length compression, trigger, wrap detection and readout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pretrig_q  <= '0;
      run_val    <= '0;
      run_cnt    <= '0;
      wr_ptr     <= '0;
      n_wr       <= '0;
      start_addr <= '0;
      rd_ptr     <= '0;
      n_rd       <= '0;
      shift_q    <= '0;
      byte_idx   <= '0;
      busy       <= 1'b0;
      triggered  <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;

      if (capturing) begin
        if (run_hit) begin
          wr_ptr  <= wr_nxt;
          if (n_wr != {AW{1'b1}}) n_wr <= n_wr + AW'(1);
          run_val <= probe_i;
          run_cnt <= '0;
        end else begin
          run_cnt <= run_cnt + CW'(1);
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            pretrig_q <= pretrig;
            run_val   <= probe_i;
            run_cnt   <= '0;
            wr_ptr    <= '0;
            n_wr      <= '0;
            busy      <= 1'b1;
            state     <= (pretrig == '0) ? WAIT_TRIG : PRE;
          end
        end
        PRE: begin
          if (n_wr >= pretrig_q) state <= WAIT_TRIG;
        end
        WAIT_TRIG: begin
          if (trig_hit) begin
            // Oldest kept entry sits pretrig slots behind the current pointer.
            start_addr <= wr_ptr - pretrig_q;
            triggered  <= 1'b1;
            state      <= POST;
          end
        end
        POST: begin
          if (run_hit && (wr_nxt == start_addr)) begin
            rd_ptr <= start_addr;
            n_rd   <= '0;
            state  <= RD_ADDR;
          end
        end
        RD_ADDR: begin
          state <= RD_LATCH;
        end
        RD_LATCH: begin
          shift_q  <= mem_rdata;
          byte_idx <= '0;
          state    <= SEND;
        end
        SEND: begin
          if (tx_ready) begin
            shift_q <= shift_q << 8;
            state   <= SEND_WAIT;
          end
        end
        SEND_WAIT: begin
          if (byte_idx != BIW'(NB - 1)) begin
            byte_idx <= byte_idx + BIW'(1);
            state    <= SEND;
          end else begin
            rd_ptr <= rd_ptr + AW'(1);
            n_rd   <= n_rd + AW'(1);
            if (n_rd != {AW{1'b1}}) begin
              state <= RD_ADDR;
            end else begin
              done      <= 1'b1;
              triggered <= 1'b0;
              busy      <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer with a behavioural RAM and UART TX.
module tb_capture_sequencer;

  localparam int DW = 8;
  localparam int CW = 8;
  localparam int AW = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [DW-1:0]  probe_i = '0;
  logic [DW-1:0]  trig_mask = '0;
  logic [DW-1:0]  trig_value = '0;
  logic [AW-1:0]  pretrig = '0;
  logic           mem_we;
  logic [AW-1:0]  mem_addr;
  logic [15:0]    mem_wdata;
  logic [15:0]    mem_rdata;
  logic [7:0]     tx_data;
  logic           tx_send;
  logic           tx_ready;
  logic           busy;
  logic           triggered;
  logic           done;

  capture_sequencer #(.DW(DW), .CW(CW), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .probe_i    (probe_i),
    .trig_mask  (trig_mask),
    .trig_value (trig_value),
    .pretrig    (pretrig),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .tx_data    (tx_data),
    .tx_send    (tx_send),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .triggered  (triggered),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Single-port RAM with a registered read.
  logic [15:0] ram [16];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // UART TX: busy for a few cycles after each strobe; tx_hold stalls it.
  logic rdy_q = 1'b1;
  int   tx_cnt = 0;
  logic tx_hold = 1'b0;
  assign tx_ready = rdy_q & ~tx_hold;
  always @(posedge clk) begin
    if (tx_send) begin
      rdy_q  <= 1'b0;
      tx_cnt <= 2;
    end else if (tx_cnt != 0) begin
      tx_cnt <= tx_cnt - 1;
      if (tx_cnt == 1) rdy_q <= 1'b1;
    end
  end

  // Monitors: bytes sent, writes performed, done pulses, strobe protocol.
  logic [7:0]  byteq [$];
  logic [3:0]  waddr_q [$];
  logic [15:0] wdata_q [$];
  int   done_cnt = 0;
  int   bad_ready = 0;
  int   bad_gap = 0;
  logic prev_send = 1'b0;
  always @(negedge clk) begin
    if (tx_send) begin
      byteq.push_back(tx_data);
      if (!tx_ready) bad_ready <= bad_ready + 1;
      if (prev_send) bad_gap <= bad_gap + 1;
    end
    prev_send <= tx_send;
    if (mem_we) begin
      waddr_q.push_back(mem_addr);
      wdata_q.push_back(mem_wdata);
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int maxc, output bit seen, output bit trig_low);
    seen = 1'b0;
    trig_low = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (!triggered) trig_low = 1'b1;
    end
  endtask

  logic [7:0] expq [32];

  task automatic chk_bytes(input string tag, input int base);
    chk({tag, "_nbytes"}, byteq.size() - base, 32);
    for (int i = 0; i < 32; i++)
      if (base + i < byteq.size())
        chk($sformatf("%s_byte%0d", tag, i), byteq[base + i], expq[i]);
  endtask

  int         bb, wb, db;
  bit         seen, tl, found;
  logic [7:0] prev, v;
  int         a;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_outs", {mem_we, mem_addr, mem_wdata, tx_data, tx_send, busy, triggered, done}, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", {mem_we, mem_addr, mem_wdata, tx_data, tx_send, busy, triggered, done}, 0);

    // Constant probe: saturated runs only; also a start pulse while busy.
    tick();
    probe_i = 8'h3C; trig_mask = 8'h00; pretrig = 4'd0; start = 1'b1;
    bb = byteq.size(); wb = waddr_q.size(); db = done_cnt;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("t1_busy", busy, 1);
    repeat (1000) tick();
    pretrig = 4'd5; start = 1'b1;
    tick();
    start = 1'b0; pretrig = 4'd0;
    @(negedge clk);
    chk("t6_busy_kept", busy, 1);
    wait_done(8000, seen, tl);
    chk("t1_done", seen, 1);
    repeat (4) @(negedge clk);
    chk("t1_done_once", done_cnt - db, 1);
    chk("t1_idle", busy, 0);
    chk("t1_nwr", waddr_q.size() - wb, 16);
    for (int j = 0; j < 16; j++)
      if (wb + j < waddr_q.size()) begin
        chk($sformatf("t1_waddr%0d", j), waddr_q[wb + j], j);
        chk($sformatf("t1_wdata%0d", j), wdata_q[wb + j], 16'h3CFF);
      end
    for (int i = 0; i < 32; i++) expq[i] = (i % 2 == 1) ? 8'hFF : 8'h3C;
    chk_bytes("t1", bb);

    // Toggling probe: a write every cycle; then stall TX for 100 cycles.
    tick();
    probe_i = 8'hFF; start = 1'b1;
    bb = byteq.size(); db = done_cnt;
    prev = 8'hFF;
    for (int i = 1; i <= 16; i++) begin
      tick();
      start = 1'b0;
      probe_i = (i % 2 == 1) ? 8'h00 : 8'hFF;
      @(negedge clk);
      chk($sformatf("t2_we%0d", i), mem_we, 1);
      chk($sformatf("t2_addr%0d", i), mem_addr, i - 1);
      chk($sformatf("t2_wdata%0d", i), mem_wdata, {prev, 8'h00});
      prev = probe_i;
    end
    tick();
    tx_hold = 1'b1;
    repeat (100) tick();
    @(negedge clk);
    chk("t4_hold_nosend", byteq.size() - bb, 0);
    chk("t4_busy", busy, 1);
    tick();
    tx_hold = 1'b0;
    wait_done(2000, seen, tl);
    chk("t2_done", seen, 1);
    repeat (3) @(negedge clk);
    chk("t2_done_once", done_cnt - db, 1);
    for (int j = 0; j < 16; j++) begin
      expq[2*j]   = (j % 2 == 0) ? 8'hFF : 8'h00;
      expq[2*j+1] = 8'h00;
    end
    chk_bytes("t4", bb);

    // Pre-trigger of 4, trigger hit while wr_ptr = 10 -> readout from 6.
    tick();
    pretrig = 4'd4; trig_mask = 8'hFF; trig_value = 8'h5A; probe_i = 8'h00; start = 1'b1;
    bb = byteq.size();
    for (int k = 1; k <= 22; k++) begin
      tick();
      start = 1'b0;
      probe_i = (k == 11) ? 8'h5A : ((k % 2 == 1) ? 8'hFF : 8'h00);
      @(negedge clk);
      if (k == 11) begin
        chk("t3_trig_addr", mem_addr, 10);
        chk("t3_trig_pre", triggered, 0);
      end
      if (k == 12) chk("t3_trig_set", triggered, 1);
      if (k == 22) chk("t3_last_addr", mem_addr, 5);
    end
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(2000, seen, tl);
    chk("t3_done", seen, 1);
    chk("t3_trig_held", tl, 0);
    chk("t3_trig_clr", triggered, 0);
    for (int i = 0; i < 16; i++) begin
      a = (6 + i) % 16;
      v = (a == 11) ? 8'h5A : ((a % 2 == 1) ? 8'hFF : 8'h00);
      expq[2*i]   = v;
      expq[2*i+1] = 8'h00;
    end
    chk_bytes("t3", bb);

    // Reset during the fifth readout byte, then a fresh capture.
    tick();
    pretrig = 4'd0; trig_mask = 8'h00; probe_i = 8'h55; start = 1'b1;
    bb = byteq.size();
    for (int i = 1; i <= 16; i++) begin
      tick();
      start = 1'b0;
      probe_i = (i % 2 == 1) ? 8'hAA : 8'h55;
    end
    found = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk); #1;
      if (tx_send && (byteq.size() - bb == 5)) begin
        found = 1'b1;
        break;
      end
    end
    chk("t5_byte5_seen", found, 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_outs", {mem_we, mem_addr, mem_wdata, tx_data, tx_send, busy, triggered, done}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    probe_i = 8'h12; start = 1'b1;
    bb = byteq.size(); db = done_cnt;
    prev = 8'h12;
    for (int i = 1; i <= 16; i++) begin
      tick();
      start = 1'b0;
      probe_i = (i % 2 == 1) ? 8'h34 : 8'h12;
      @(negedge clk);
      chk($sformatf("t5_addr%0d", i), mem_addr, i - 1);
      chk($sformatf("t5_wdata%0d", i), mem_wdata, {prev, 8'h00});
      prev = probe_i;
    end
    wait_done(2000, seen, tl);
    chk("t5_done", seen, 1);
    repeat (3) @(negedge clk);
    chk("t5_done_once", done_cnt - db, 1);
    for (int j = 0; j < 16; j++) begin
      expq[2*j]   = (j % 2 == 0) ? 8'h12 : 8'h34;
      expq[2*j+1] = 8'h00;
    end
    chk_bytes("t5", bb);

    chk("send_while_not_ready", bad_ready, 0);
    chk("send_adjacent", bad_gap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
